// File: rtl/wb_commit.sv
// wb_commit: orders two lane results by tag, commits to RF ports, issues redirect and flush.
// Optional WB_PERF_CNT_EN adds commit_cnt/squash_cnt performance counters.
module wb_commit #(
  parameter int DATA_W       = 32,
  parameter int PC_W         = 32,
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop,
  input  logic              a_valid,
  input  logic              a_num,
  input  logic              a_rfwe,
  input  logic [REG_AW-1:0] a_rfwaddr,
  input  logic [DATA_W-1:0] a_rfwdata,
  input  logic              a_branch_flag,
  input  logic [PC_W-1:0]   a_branch_address,
  input  logic              b_valid,
  input  logic              b_num,
  input  logic              b_rfwe,
  input  logic [REG_AW-1:0] b_rfwaddr,
  input  logic [DATA_W-1:0] b_rfwdata,
  input  logic              b_branch_flag,
  input  logic [PC_W-1:0]   b_branch_address,
  output logic              rf_we0,
  output logic [REG_AW-1:0] rf_waddr0,
  output logic [DATA_W-1:0] rf_wdata0,
  output logic              rf_we1,
  output logic [REG_AW-1:0] rf_waddr1,
  output logic [DATA_W-1:0] rf_wdata1,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flush,
  output logic              order_err
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]       commit_cnt,
  output logic [31:0]       squash_cnt
`endif
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_a_valid, r_a_num, r_a_rfwe, r_a_br;
  logic r_b_valid, r_b_num, r_b_rfwe, r_b_br;
  logic [REG_AW-1:0] r_a_waddr, r_b_waddr;
  logic [DATA_W-1:0] r_a_wdata, r_b_wdata;
  logic [PC_W-1:0] r_a_baddr, r_b_baddr;
  logic r_redirect;
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_a_valid, r_a_num, r_a_rfwe, r_a_br, r_b_valid, r_b_num, r_b_rfwe, r_b_br} <= '0;
      {r_a_waddr, r_b_waddr, r_a_wdata, r_b_wdata, r_a_baddr, r_b_baddr} <= '0;
    end else if (!stop) begin
      {r_a_valid, r_a_num, r_a_rfwe, r_a_br} <= {a_valid, a_num, a_rfwe, a_branch_flag};
      {r_b_valid, r_b_num, r_b_rfwe, r_b_br} <= {b_valid, b_num, b_rfwe, b_branch_flag};
      {r_a_waddr, r_a_wdata, r_a_baddr} <= {a_rfwaddr, a_rfwdata, a_branch_address};
      {r_b_waddr, r_b_wdata, r_b_baddr} <= {b_rfwaddr, b_rfwdata, b_branch_address};
    end
  end
  // Wrong-path results are discarded by masking their valids while flushing.
  logic w_va, w_vb, w_a_old, w_ov, w_yv, w_o_rfwe, w_y_rfwe, w_o_br, w_y_br, w_redir, w_we0, w_we1;
  logic [REG_AW-1:0] w_o_waddr, w_y_waddr;
  logic [DATA_W-1:0] w_o_wdata, w_y_wdata;
  logic [PC_W-1:0] w_o_baddr, w_y_baddr;
  assign w_va    = r_a_valid & ~flush;
  assign w_vb    = r_b_valid & ~flush;
  assign w_a_old = w_va & (~w_vb | ~r_a_num | r_b_num);
  assign w_ov    = w_va | w_vb;
  assign w_yv    = w_va & w_vb;
  assign w_o_rfwe  = w_a_old ? r_a_rfwe  : r_b_rfwe;
  assign w_y_rfwe  = w_a_old ? r_b_rfwe  : r_a_rfwe;
  assign w_o_waddr = w_a_old ? r_a_waddr : r_b_waddr;
  assign w_y_waddr = w_a_old ? r_b_waddr : r_a_waddr;
  assign w_o_wdata = w_a_old ? r_a_wdata : r_b_wdata;
  assign w_y_wdata = w_a_old ? r_b_wdata : r_a_wdata;
  assign w_o_baddr = w_a_old ? r_a_baddr : r_b_baddr;
  assign w_y_baddr = w_a_old ? r_b_baddr : r_a_baddr;
  assign w_o_br  = w_ov & (w_a_old ? r_a_br : r_b_br);
  assign w_y_br  = w_yv & (w_a_old ? r_b_br : r_a_br);
  assign w_redir = w_o_br | w_y_br;
  assign w_we1   = w_yv & w_y_rfwe & (w_y_waddr != '0) & ~w_o_br;
  assign w_we0   = w_ov & w_o_rfwe & (w_o_waddr != '0) & ~(w_we1 & (w_o_waddr == w_y_waddr));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (!stop) begin
      r_state <= w_next;
      r_cnt   <= (r_state == IDLE) ? (w_redir ? 4'(FLUSH_CYCLES) : '0) : r_cnt - 4'd1;
    end
  end
  always_comb w_next = (r_state == IDLE) ? (w_redir ? FLUSH : IDLE) : ((r_cnt == 4'd1) ? IDLE : FLUSH);
  always_comb flush = (r_state == FLUSH);
  always_ff @(posedge clk) begin
    if (rst) begin
      {rf_we0, rf_waddr0, rf_wdata0, rf_we1, rf_waddr1, rf_wdata1} <= '0;
      {r_redirect, redirect_pc, order_err} <= '0;
    end else if (!stop) begin
      rf_we0      <= w_we0;
      rf_waddr0   <= w_we0 ? w_o_waddr : '0;
      rf_wdata0   <= w_we0 ? w_o_wdata : '0;
      rf_we1      <= w_we1;
      rf_waddr1   <= w_we1 ? w_y_waddr : '0;
      rf_wdata1   <= w_we1 ? w_y_wdata : '0;
      r_redirect  <= w_redir;
      redirect_pc <= w_o_br ? w_o_baddr : (w_y_br ? w_y_baddr : '0);
      order_err   <= order_err | (w_yv & (r_a_num == r_b_num));
    end
  end
  // A pending pulse is hidden during stop and shown again once the pipeline moves.
  assign redirect_valid = r_redirect & ~stop;
`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_cnt <= '0;
      squash_cnt <= '0;
    end else if (!stop) begin
      commit_cnt <= commit_cnt + 32'(w_we0) + 32'(w_we1);
      squash_cnt <= squash_cnt + (flush ? 32'(r_a_valid) + 32'(r_b_valid) : 32'(w_o_br & w_yv));
    end
  end
`endif
endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: directed self-checking bench for wb_commit.
module tb_wb_commit;
  logic clk = 0, rst = 1, stop = 0;
  logic a_valid, a_num, a_rfwe, a_branch_flag, b_valid, b_num, b_rfwe, b_branch_flag;
  logic [4:0] a_rfwaddr, b_rfwaddr, rf_waddr0, rf_waddr1;
  logic [31:0] a_rfwdata, b_rfwdata, a_branch_address, b_branch_address, rf_wdata0, rf_wdata1, redirect_pc;
  logic rf_we0, rf_we1, redirect_valid, flush, order_err;
`ifdef WB_PERF_CNT_EN
  logic [31:0] commit_cnt, squash_cnt;
`endif
  int checks = 0, errors = 0;
  wb_commit dut (
    .clk(clk), .rst(rst), .stop(stop),
    .a_valid(a_valid), .a_num(a_num), .a_rfwe(a_rfwe), .a_rfwaddr(a_rfwaddr), .a_rfwdata(a_rfwdata),
    .a_branch_flag(a_branch_flag), .a_branch_address(a_branch_address),
    .b_valid(b_valid), .b_num(b_num), .b_rfwe(b_rfwe), .b_rfwaddr(b_rfwaddr), .b_rfwdata(b_rfwdata),
    .b_branch_flag(b_branch_flag), .b_branch_address(b_branch_address),
    .rf_we0(rf_we0), .rf_waddr0(rf_waddr0), .rf_wdata0(rf_wdata0),
    .rf_we1(rf_we1), .rf_waddr1(rf_waddr1), .rf_wdata1(rf_wdata1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush), .order_err(order_err)
`ifdef WB_PERF_CNT_EN
    , .commit_cnt(commit_cnt), .squash_cnt(squash_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic clr;
    {a_valid, a_num, a_rfwe, a_branch_flag, b_valid, b_num, b_rfwe, b_branch_flag} = '0;
    {a_rfwaddr, b_rfwaddr, a_rfwdata, b_rfwdata, a_branch_address, b_branch_address} = '0;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic lane_a(input logic n, input logic we, input logic [4:0] ad, input logic [31:0] d, input logic br, input logic [31:0] pc);
    {a_valid, a_num, a_rfwe, a_rfwaddr, a_rfwdata, a_branch_flag, a_branch_address} = {1'b1, n, we, ad, d, br, pc};
  endtask
  task automatic lane_b(input logic n, input logic we, input logic [4:0] ad, input logic [31:0] d, input logic br, input logic [31:0] pc);
    {b_valid, b_num, b_rfwe, b_rfwaddr, b_rfwdata, b_branch_flag, b_branch_address} = {1'b1, n, we, ad, d, br, pc};
  endtask
  task automatic test_reset;
    rst = 1; clr; step; step;
    checks++;
    if ({rf_we0, rf_waddr0, rf_wdata0, rf_we1, rf_waddr1, rf_wdata1, redirect_valid, redirect_pc, flush, order_err} !== '0) begin
      errors++; $display("FAIL reset: outputs %h %h %h %h %h %h %b %h %b %b required all 0", rf_we0, rf_waddr0, rf_wdata0, rf_we1, rf_waddr1, rf_wdata1, redirect_valid, redirect_pc, flush, order_err);
    end
    rst = 0;
  endtask
  task automatic test_single;
    lane_a(0, 1, 5, 32'h1234, 0, 0); step; clr; step;
    checks++;
    if ({rf_we0, rf_waddr0, rf_wdata0, rf_we1, rf_waddr1, rf_wdata1, redirect_valid} !== {1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0}) begin
      errors++; $display("FAIL single: got we0=%b a0=%0d d0=%h we1=%b a1=%0d d1=%h rv=%b required 1 5 1234 0 0 0 0", rf_we0, rf_waddr0, rf_wdata0, rf_we1, rf_waddr1, rf_wdata1, redirect_valid);
    end
    step; checks++;
    if (rf_we0 !== 1'b0) begin errors++; $display("FAIL single_idle: we0=%b required 0", rf_we0); end
  endtask
  task automatic test_reorder;
    lane_a(1, 1, 3, 32'hAA, 0, 0); lane_b(0, 1, 4, 32'hBB, 0, 0); step; clr; step;
    checks++;
    if ({rf_we0, rf_waddr0, rf_wdata0, rf_we1, rf_waddr1, rf_wdata1} !== {1'b1, 5'd4, 32'hBB, 1'b1, 5'd3, 32'hAA}) begin
      errors++; $display("FAIL reorder: got %b %0d %h / %b %0d %h required 1 4 bb / 1 3 aa", rf_we0, rf_waddr0, rf_wdata0, rf_we1, rf_waddr1, rf_wdata1);
    end
  endtask
  task automatic test_branch;
    lane_b(0, 0, 0, 0, 1, 32'h80); lane_a(1, 1, 7, 32'h77, 0, 0); step; clr; step;
    checks++;
    if ({redirect_valid, redirect_pc, rf_we0, rf_we1, flush} !== {1'b1, 32'h80, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL branch: rv=%b pc=%h we0=%b we1=%b flush=%b required 1 80 0 0 1", redirect_valid, redirect_pc, rf_we0, rf_we1, flush);
    end
    lane_a(0, 1, 6, 32'h66, 0, 0); lane_b(1, 0, 0, 0, 1, 32'h300); step; clr;
    checks++;
    if ({redirect_valid, flush, rf_we0} !== 3'b010) begin
      errors++; $display("FAIL branch_flush1: rv=%b flush=%b we0=%b required 0 1 0", redirect_valid, flush, rf_we0);
    end
    step; checks++;
    if ({redirect_valid, flush, rf_we0, rf_we1} !== 4'b0000) begin
      errors++; $display("FAIL branch_drop: rv=%b flush=%b we0=%b we1=%b required 0 0 0 0", redirect_valid, flush, rf_we0, rf_we1);
    end
    lane_a(0, 1, 8, 32'h88, 0, 0); step; clr; step; checks++;
    if ({rf_we0, rf_waddr0, rf_wdata0} !== {1'b1, 5'd8, 32'h88}) begin
      errors++; $display("FAIL branch_after: got %b %0d %h required 1 8 88", rf_we0, rf_waddr0, rf_wdata0);
    end
  endtask
  task automatic test_waw;
    lane_a(0, 1, 9, 32'd1, 0, 0); lane_b(1, 1, 9, 32'd2, 0, 0); step; clr; step; checks++;
    if ({rf_we0, rf_waddr0, rf_wdata0, rf_we1, rf_waddr1, rf_wdata1} !== {1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'd2}) begin
      errors++; $display("FAIL waw: got %b %0d %h / %b %0d %h required 0 0 0 / 1 9 2", rf_we0, rf_waddr0, rf_wdata0, rf_we1, rf_waddr1, rf_wdata1);
    end
    lane_a(0, 1, 0, 32'd5, 0, 0); lane_b(1, 1, 0, 32'd6, 0, 0); step; clr; step; checks++;
    if ({rf_we0, rf_wdata0, rf_we1, rf_wdata1} !== '0) begin
      errors++; $display("FAIL x0: we0=%b d0=%h we1=%b d1=%h required all 0", rf_we0, rf_wdata0, rf_we1, rf_wdata1);
    end
    lane_a(0, 1, 1, 32'h11, 0, 0); lane_b(1, 1, 2, 32'h22, 1, 32'h100); step; clr; step; checks++;
    if ({rf_we0, rf_waddr0, rf_we1, rf_waddr1, redirect_valid, redirect_pc} !== {1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 32'h100}) begin
      errors++; $display("FAIL young_branch: we0=%b a0=%0d we1=%b a1=%0d rv=%b pc=%h required 1 1 1 2 1 100", rf_we0, rf_waddr0, rf_we1, rf_waddr1, redirect_valid, redirect_pc);
    end
    step; step;
  endtask
  task automatic test_stop_reset;
    lane_a(0, 0, 0, 0, 1, 32'h40); step; clr; step;
    stop = 1; step; step; checks++;
    if ({flush, redirect_valid} !== 2'b10) begin
      errors++; $display("FAIL stop_hold: flush=%b rv=%b required 1 0", flush, redirect_valid);
    end
    stop = 0; #1; checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL stop_release: rv=%b pc=%h required 1 40", redirect_valid, redirect_pc);
    end
    step; checks++;
    if ({flush, redirect_valid} !== 2'b10) begin
      errors++; $display("FAIL stop_cnt: flush=%b rv=%b required 1 0", flush, redirect_valid);
    end
    step; checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL stop_end: flush=%b required 0", flush); end
    lane_a(0, 1, 5, 32'h7, 1, 32'h44); step; clr; step; checks++;
    if ({flush, redirect_valid, rf_we0} !== 3'b111) begin
      errors++; $display("FAIL rst_pre: flush=%b rv=%b we0=%b required 1 1 1", flush, redirect_valid, rf_we0);
    end
    rst = 1; step; rst = 0; checks++;
    if ({flush, redirect_valid, redirect_pc, rf_we0, rf_waddr0, rf_wdata0} !== '0) begin
      errors++; $display("FAIL rst_flush: flush=%b rv=%b pc=%h we0=%b a0=%0d d0=%h required all 0", flush, redirect_valid, redirect_pc, rf_we0, rf_waddr0, rf_wdata0);
    end
    lane_a(1, 1, 10, 32'h3, 0, 0); lane_b(1, 1, 11, 32'h4, 0, 0); step; clr; step; checks++;
    if ({order_err, rf_waddr0, rf_waddr1} !== {1'b1, 5'd10, 5'd11}) begin
      errors++; $display("FAIL order_err: err=%b a0=%0d a1=%0d required 1 10 11", order_err, rf_waddr0, rf_waddr1);
    end
    step; step; checks++;
    if (order_err !== 1'b1) begin errors++; $display("FAIL order_sticky: err=%b required 1", order_err); end
    stop = 1; rst = 1; step; stop = 0; rst = 0; checks++;
    if (order_err !== 1'b0) begin errors++; $display("FAIL rst_over_stop: err=%b required 0", order_err); end
  endtask
  task automatic test_back_to_back;
    lane_a(0, 1, 1, 32'h10, 0, 0); lane_b(1, 1, 2, 32'h20, 0, 0); step;
    lane_a(1, 1, 3, 32'h30, 0, 0); lane_b(0, 1, 4, 32'h40, 0, 0); step; checks++;
    if ({rf_waddr0, rf_wdata0, rf_waddr1, rf_wdata1} !== {5'd1, 32'h10, 5'd2, 32'h20}) begin
      errors++; $display("FAIL b2b_1: got %0d %h %0d %h required 1 10 2 20", rf_waddr0, rf_wdata0, rf_waddr1, rf_wdata1);
    end
    lane_a(0, 1, 5, 32'h50, 0, 0); lane_b(1, 1, 6, 32'h60, 0, 0); step; checks++;
    if ({rf_waddr0, rf_wdata0, rf_waddr1, rf_wdata1} !== {5'd4, 32'h40, 5'd3, 32'h30}) begin
      errors++; $display("FAIL b2b_2: got %0d %h %0d %h required 4 40 3 30", rf_waddr0, rf_wdata0, rf_waddr1, rf_wdata1);
    end
    clr; step; checks++;
    if ({rf_we0, rf_waddr0, rf_we1, rf_waddr1} !== {1'b1, 5'd5, 1'b1, 5'd6}) begin
      errors++; $display("FAIL b2b_3: got %b %0d %b %0d required 1 5 1 6", rf_we0, rf_waddr0, rf_we1, rf_waddr1);
    end
  endtask
`ifdef WB_PERF_CNT_EN
  task automatic test_perf;
    rst = 1; step; rst = 0;
    for (int i = 0; i < 3; i++) begin
      lane_a(0, 1, 5'(i + 1), 32'(i), 0, 0); lane_b(1, 1, 5'(i + 10), 32'(i), 0, 0); step;
    end
    lane_a(0, 0, 0, 0, 1, 32'h200); lane_b(1, 1, 7, 32'h7, 0, 0); step; clr; step; step; step; step;
    checks++;
    if ({commit_cnt, squash_cnt} !== {32'd6, 32'd1}) begin
      errors++; $display("FAIL perf: commit=%0d squash=%0d required 6 1", commit_cnt, squash_cnt);
    end
  endtask
`endif
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at 100000");
    $fatal(1);
  end
  initial begin
    clr;
    test_reset;
    test_single;
    test_reorder;
    test_branch;
    test_waw;
    test_stop_reset;
    test_back_to_back;
`ifdef WB_PERF_CNT_EN
    test_perf;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Receiving end of the execution-unit result interface for the dual-issue core.
- Takes the two per-lane execution results (ordering tag, register write, branch redirect), orders them by tag, and commits them to the register-file write ports.
- Resolves the fetch redirect from the oldest taken branch and squashes younger and wrong-path results.
- Sits between the two execution units and the register file / PC-select logic.

Parameters:
DATA_W, 32, register data width
PC_W, 32, PC / branch target width
REG_AW, 5, register address width
FLUSH_CYCLES, 2, cycles of wrong-path input dropped after a redirect (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stop  in  1  pipeline hold; freezes all internal state
a_valid  in  1  lane A result valid
a_num  in  1  lane A ordering tag; 0 = older
a_rfwe  in  1  lane A register write enable
a_rfwaddr  in  REG_AW  lane A destination register
a_rfwdata  in  DATA_W  lane A write data
a_branch_flag  in  1  lane A branch taken
a_branch_address  in  PC_W  lane A branch target
b_*  in  same set as lane A  lane B result
rf_we0  out  1  register-file write port 0 enable (older instruction)
rf_waddr0  out  REG_AW  port 0 address
rf_wdata0  out  DATA_W  port 0 data
rf_we1  out  1  register-file write port 1 enable (younger instruction)
rf_waddr1  out  REG_AW  port 1 address
rf_wdata1  out  DATA_W  port 1 data
redirect_valid  out  1  one-cycle fetch redirect pulse
redirect_pc  out  PC_W  redirect target
flush  out  1  high while the FSM is in FLUSH
order_err  out  1  sticky flag: both lanes valid with equal tags

Behaviour:
- Stage 1 input register: captures the lane inputs each cycle when stop=0.
- All outputs are registered from stage 1. Latency is 1 cycle: inputs at edge N produce outputs after edge N+1.
- Ordering:
  - Older lane = the valid lane with num=0.
  - If exactly one lane is valid, it is the older lane.
  - If both lanes are valid with equal num: lane A is treated as older and order_err is set. order_err is sticky until rst.
- Write rules:
  - The older instruction maps to port 0, the younger to port 1.
  - rf_weX = valid & rfwe & (waddr != 0).
  - If the older instruction branched, the younger write is suppressed (rf_we1=0).
  - If both write the same nonzero register, port 0 is suppressed and the younger write wins.
  - When a write enable is 0, the matching address and data outputs are 0.
- Redirect:
  - If the older instruction branched, redirect_pc = its target.
  - Otherwise, if the younger instruction branched, redirect_pc = the younger target.
  - redirect_valid is high for exactly one cycle.
- FSM:
  - States: IDLE, FLUSH.
  - IDLE→FLUSH when a redirect is issued; the counter loads FLUSH_CYCLES.
  - In FLUSH: all incoming valids are treated as 0 (no writes, no redirect). The counter decrements each non-stop cycle.
  - FLUSH→IDLE when the counter reaches 1 and decrements.
  - A branch arriving during FLUSH is ignored.
- stop=1: stage registers, FSM, counter and all outputs hold their values. redirect_valid is forced to 0 while stop=1 and is re-presented when stop drops.
- Reset values: all outputs 0, FSM=IDLE, counter=0, order_err=0. rst during FLUSH returns to IDLE immediately. rst has priority over stop.

Optional Feature:
- WB_PERF_CNT_EN defined:
  - Adds output ports commit_cnt (32 bits) and squash_cnt (32 bits), reset to 0.
  - commit_cnt += number of asserted rf_we0/rf_we1 in each non-stop cycle.
  - squash_cnt += number of valid results dropped by FLUSH or by older-branch suppression.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single lane commit: a_valid=1, a_num=0, a_rfwe=1, a_rfwaddr=5, a_rfwdata=0x1234 → next cycle rf_we0=1, rf_waddr0=5, rf_wdata0=0x1234; rf_we1=0.
- Reordering: A(num=1, x3=0xAA) and B(num=0, x4=0xBB) → port0 = x4/0xBB, port1 = x3/0xAA.
- Older branch: B(num=0) with branch_flag=1 and target 0x80, A(num=1) writing x7 → redirect_valid pulse with redirect_pc=0x80; rf_we1=0; flush high for 2 cycles, during which valid inputs produce no writes.
- WAW conflict and x0: both lanes write x9 (older 1, younger 2) → only rf_we1=1 with data 2. Any write to x0 → no enable.
- Stop and reset: set stop=1 during FLUSH → counter and flush hold. Assert rst mid-FLUSH → flush=0 and outputs 0 the next cycle. Equal tags → order_err=1 and stays 1 until rst.
- With WB_PERF_CNT_EN: run 3 dual-write cycles plus 1 squash → commit_cnt=6, squash_cnt=1.
